// File: rtl/fpu_cmp_pkg.sv
// rtl/fpu_cmp_pkg.sv - shared types and constants for the FP80 compare/classify engine
package fpu_cmp_pkg;

  localparam int EXP_W  = 15;
  localparam int MANT_W = 64;
  localparam int FP_W   = 80;

  localparam logic [EXP_W-1:0] EXP_MAX       = 15'h7FFF;
  localparam logic [FP_W-1:0]  FP80_POS_ZERO = '0;

  localparam logic [1:0] OP_FCOM = 2'b00;
  localparam logic [1:0] OP_FTST = 2'b01;
  localparam logic [1:0] OP_FXAM = 2'b10;

  // Encodings equal the FXAM C3C2C0 code for each class
  typedef enum logic [2:0] {
    CLS_UNSUP  = 3'b000,
    CLS_NAN    = 3'b001,
    CLS_NORMAL = 3'b010,
    CLS_INF    = 3'b011,
    CLS_ZERO   = 3'b100,
    CLS_EMPTY  = 3'b101,
    CLS_DENORM = 3'b110
  } fp_class_t;

  localparam logic [2:0] CC_GT    = 3'b000;
  localparam logic [2:0] CC_LT    = 3'b001;
  localparam logic [2:0] CC_EQ    = 3'b100;
  localparam logic [2:0] CC_UNORD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_COMPARE,
    ST_DONE
  } state_t;

  // Expand a C3C2C0 code plus C1 into the {C3,C2,C1,C0} bus order
  function automatic logic [3:0] pack_cc(input logic [2:0] c320, input logic c1);
    return {c320[2], c320[1], c1, c320[0]};
  endfunction

endpackage

// File: rtl/fp80_classify.sv
// rtl/fp80_classify.sv - combinational FP80 class and sign decode
module fp80_classify
  import fpu_cmp_pkg::*;
(
  input  logic [FP_W-1:0] value,
  input  logic            empty,
  output fp_class_t       cls,
  output logic            sign
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;

  assign exp_f  = value[FP_W-2:MANT_W];
  assign mant_f = value[MANT_W-1:0];
  assign sign   = value[FP_W-1];

  always_comb begin
    cls = CLS_NORMAL;
    if (empty) begin
      cls = CLS_EMPTY;
    end else if (exp_f == '0 && mant_f == '0) begin
      cls = CLS_ZERO;
    end else if (exp_f == '0) begin
      cls = CLS_DENORM;
    end else if (exp_f == EXP_MAX && mant_f == {1'b1, {(MANT_W-1){1'b0}}}) begin
      cls = CLS_INF;
    end else if (exp_f == EXP_MAX && mant_f[MANT_W-1] && mant_f[MANT_W-2:0] != '0) begin
      cls = CLS_NAN;
    end else if (!mant_f[MANT_W-1]) begin
      cls = CLS_UNSUP;
    end
  end

endmodule

// File: rtl/fpu_compare_unit.sv
// rtl/fpu_compare_unit.sv - multi-cycle FCOM/FTST/FXAM engine producing condition codes and flags
module fpu_compare_unit
  import fpu_cmp_pkg::*;
#(
  parameter bit CLEAR_C1_ON_CMP = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [FP_W-1:0] operand_a,
  input  logic [FP_W-1:0] operand_b,
  input  logic            empty_a,
  input  logic            empty_b,
  output logic            busy,
  output logic            done,
  output logic [3:0]      cc,
  output logic            invalid,
  output logic            stack_fault
);

  state_t          state, state_next;
  logic [1:0]      op_q;
  logic [FP_W-1:0] a_q, b_q;
  logic            ea_q, eb_q;
  fp_class_t       cls_a, cls_b, cls_a_q, cls_b_q;
  logic            sign_a, sign_b, sign_a_q, sign_b_q;
  logic [3:0]      cc_q, cc_next;
  logic            invalid_q, invalid_next;
  logic            sf_q, sf_next;

  fp80_classify u_class_a (.value(a_q), .empty(ea_q), .cls(cls_a), .sign(sign_a));
  fp80_classify u_class_b (.value(b_q), .empty(eb_q), .cls(cls_b), .sign(sign_b));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ea_q      <= 1'b0;
      eb_q      <= 1'b0;
      cls_a_q   <= CLS_ZERO;
      cls_b_q   <= CLS_ZERO;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      cc_q      <= '0;
      invalid_q <= 1'b0;
      sf_q      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start) begin
        op_q <= op;
        a_q  <= operand_a;
        ea_q <= empty_a;
        // FTST is an FCOM against a present +0.0
        b_q  <= (op == OP_FTST) ? FP80_POS_ZERO : operand_b;
        eb_q <= (op == OP_FTST) ? 1'b0 : empty_b;
      end
      if (state == ST_CLASSIFY) begin
        cls_a_q  <= cls_a;
        cls_b_q  <= cls_b;
        sign_a_q <= sign_a;
        sign_b_q <= sign_b;
      end
      if (state == ST_COMPARE) begin
        cc_q      <= cc_next;
        invalid_q <= invalid_next;
        sf_q      <= sf_next;
      end
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_CLASSIFY;
      end
      ST_CLASSIFY: state_next = ST_COMPARE;
      ST_COMPARE:  state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  logic [FP_W-2:0] mag_a, mag_b;
  logic [2:0]      ord_code;
  logic            c1_cmp;

  assign mag_a  = a_q[FP_W-2:0];
  assign mag_b  = b_q[FP_W-2:0];
  assign c1_cmp = CLEAR_C1_ON_CMP ? 1'b0 : cc_q[1];

  // Sign-magnitude ordering; magnitude sense flips when both are negative
  always_comb begin
    ord_code = CC_EQ;
    if (cls_a_q == CLS_ZERO && cls_b_q == CLS_ZERO) begin
      ord_code = CC_EQ;
    end else if (sign_a_q != sign_b_q) begin
      ord_code = sign_a_q ? CC_LT : CC_GT;
    end else if (mag_a == mag_b) begin
      ord_code = CC_EQ;
    end else begin
      ord_code = ((mag_a > mag_b) ^ sign_a_q) ? CC_GT : CC_LT;
    end
  end

  always_comb begin
    cc_next      = '0;
    invalid_next = 1'b0;
    sf_next      = 1'b0;
    case (op_q)
      OP_FCOM, OP_FTST: begin
        if (cls_a_q == CLS_EMPTY || cls_b_q == CLS_EMPTY) begin
          cc_next      = pack_cc(CC_UNORD, c1_cmp);
          invalid_next = 1'b1;
          sf_next      = 1'b1;
        end else if (cls_a_q == CLS_NAN || cls_a_q == CLS_UNSUP ||
                     cls_b_q == CLS_NAN || cls_b_q == CLS_UNSUP) begin
          cc_next      = pack_cc(CC_UNORD, c1_cmp);
          invalid_next = 1'b1;
        end else begin
          cc_next = pack_cc(ord_code, c1_cmp);
        end
      end
      OP_FXAM: cc_next = pack_cc(cls_a_q, sign_a_q);
      default: invalid_next = 1'b1;
    endcase
  end

  assign cc          = cc_q;
  assign invalid     = invalid_q;
  assign stack_fault = sf_q;

endmodule

// File: tb/tb_fpu_compare_unit.sv
// tb/tb_fpu_compare_unit.sv - directed vector bench for fpu_compare_unit
module tb_fpu_compare_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [79:0] operand_a, operand_b;
  logic        empty_a, empty_b;
  logic        busy, done;
  logic [3:0]  cc;
  logic        invalid, stack_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_compare_unit #(.CLEAR_C1_ON_CMP(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .empty_a(empty_a), .empty_b(empty_b),
    .busy(busy), .done(done), .cc(cc),
    .invalid(invalid), .stack_fault(stack_fault)
  );

  typedef struct {
    logic [1:0]  op;
    logic [79:0] a;
    logic [79:0] b;
    logic        ea;
    logic        eb;
    logic [3:0]  cc;
    logic        inv;
    logic        sf;
  } vec_t;

  localparam logic [79:0] P1   = 80'h3FFF_8000000000000000;
  localparam logic [79:0] P2   = 80'h4000_8000000000000000;
  localparam logic [79:0] N1   = 80'hBFFF_8000000000000000;
  localparam logic [79:0] N2   = 80'hC000_8000000000000000;
  localparam logic [79:0] PZ   = 80'h0000_0000000000000000;
  localparam logic [79:0] NZ   = 80'h8000_0000000000000000;
  localparam logic [79:0] PINF = 80'h7FFF_8000000000000000;
  localparam logic [79:0] NINF = 80'hFFFF_8000000000000000;
  localparam logic [79:0] QNAN = 80'h7FFF_C000000000000000;
  localparam logic [79:0] PINV = 80'h7FFF_0000000000000000;
  localparam logic [79:0] DEN  = 80'h0000_4000000000000000;
  localparam logic [79:0] UNN  = 80'h4000_0000000000000001;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int cnt;
    @(negedge clk);
    op = v.op; operand_a = v.a; operand_b = v.b;
    empty_a = v.ea; empty_b = v.eb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = ~v.op; operand_a = ~v.a; operand_b = ~v.b;
    empty_a = ~v.ea; empty_b = ~v.eb;
    chk({nm, " busy"}, {79'd0, busy}, 80'd1);
    cnt = 1;
    while (!done && cnt < 12) begin
      @(negedge clk);
      cnt++;
    end
    chk({nm, " latency"}, 80'(cnt), 80'd3);
    chk({nm, " cc"}, {76'd0, cc}, {76'd0, v.cc});
    chk({nm, " invalid"}, {79'd0, invalid}, {79'd0, v.inv});
    chk({nm, " stack_fault"}, {79'd0, stack_fault}, {79'd0, v.sf});
    @(negedge clk);
    chk({nm, " idle"}, {78'd0, busy, done}, 80'd0);
    chk({nm, " cc hold"}, {76'd0, cc}, {76'd0, v.cc});
  endtask

  initial begin
    int dones;
    vecs[0]  = '{2'b00, P1,   P2, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, NZ,   PZ, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, N1,   N2, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, QNAN, P1, 1'b0, 1'b0, 4'b1101, 1'b1, 1'b0};
    vecs[4]  = '{2'b00, P1,   P2, 1'b0, 1'b1, 4'b1101, 1'b1, 1'b1};
    vecs[5]  = '{2'b10, DEN,  P1, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, NINF, P1, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, UNN,  P1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, P1,   P1, 1'b1, 1'b0, 4'b1001, 1'b0, 1'b0};
    vecs[9]  = '{2'b10, N1,   P1, 1'b1, 1'b0, 4'b1011, 1'b0, 1'b0};
    vecs[10] = '{2'b01, N1,   P2, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0};
    vecs[11] = '{2'b11, P1,   P2, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[12] = '{2'b00, PINF, PINF, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0};
    vecs[13] = '{2'b00, P2,   P1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[14] = '{2'b10, QNAN, P1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
    vecs[15] = '{2'b00, PINV, P1, 1'b0, 1'b0, 4'b1101, 1'b1, 1'b0};
    vecs[16] = '{2'b00, P1,   N2, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[17] = '{2'b10, PZ,   P1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0};
    vecs[18] = '{2'b10, P1,   P1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0};
    vecs[19] = '{2'b01, PZ,   P1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0};
    vecs[20] = '{2'b00, P1,   PINF, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; op = 2'b00;
    operand_a = '0; operand_b = '0; empty_a = 1'b0; empty_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", {79'd0, busy}, 80'd0);
    chk("reset done", {79'd0, done}, 80'd0);
    chk("reset cc", {76'd0, cc}, 80'd0);
    chk("reset invalid", {79'd0, invalid}, 80'd0);
    chk("reset stack_fault", {79'd0, stack_fault}, 80'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Extra start pulses while busy must not launch a second operation
    @(negedge clk);
    op = 2'b01; operand_a = N1; operand_b = P2; empty_a = 1'b0; empty_b = 1'b0;
    start = 1'b1;
    @(negedge clk);
    op = 2'b10;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) start = 1'b0;
      if (done) dones++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy start done count", 80'(dones), 80'd1);
    chk("busy start cc", {76'd0, cc}, 80'b0001);

    // Reset during COMPARE aborts the operation
    @(negedge clk);
    op = 2'b00; operand_a = P1; operand_b = P1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort busy", {79'd0, busy}, 80'd0);
    chk("abort done", {79'd0, done}, 80'd0);
    chk("abort cc", {76'd0, cc}, 80'd0);
    chk("abort invalid", {79'd0, invalid}, 80'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("abort no done", 80'(dones), 80'd0);
    run_op(vecs[3], "after abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
